// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debounce front end.
package debounce_pkg;

    // Default synchronizer depth and stability window (10 ms at 25 MHz).
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;

    // Per-channel debounce state.
    typedef enum logic {
        DB_IDLE,
        DB_PENDING
    } db_state_t;

    // Width of the stability counter; it only ever holds 0 .. cycles-1.
    function automatic int unsigned cnt_w(input int unsigned cycles);
        return unsigned'($clog2(cycles));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: metastability synchronizer, stability counter FSM and
// registered rise/fall strobes coincident with the debounced level update.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_raw_i,
    output logic sw_db_o,
    output logic sw_rise_o,
    output logic sw_fall_o,
    // Combinational "accept happens on the next edge" flag, lets the top
    // register a shared change strobe that lines up with rise/fall.
    output logic accept_o
);

    localparam int unsigned    CntW   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_sync;

    db_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            db_q, db_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    // Plain shift chain; raw pin goes straight into the first flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
        end
    end

    assign sw_sync = sync_q[SYNC_STAGES-1];

    // Debounce state, counter, accepted level and strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: count consecutive mismatching samples, accept at the window end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            DB_IDLE: begin
                cnt_d = '0;
                if (sw_sync != db_q) begin
                    state_d = DB_PENDING;
                    cnt_d   = CntW'(1);
                end
            end
            DB_PENDING: begin
                if (sw_sync == db_q) begin
                    // Bounced back before the window filled: drop the count.
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                    db_d    = sw_sync;
                    rise_d  = sw_sync;
                    fall_d  = ~sw_sync;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    assign sw_db_o   = db_q;
    assign sw_rise_o = rise_q;
    assign sw_fall_o = fall_q;
    assign accept_o  = rise_d | fall_d;

    // Rise and fall come from one accept of a single level, so never overlap.
    rise_fall_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rise_q && fall_q));

endmodule

// File: rtl/switch_debounce_sync.sv
// Switch front end for the adder: NUM_SW independent debounced channels plus a
// single-cycle strobe whenever any operand level is accepted.
module switch_debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sw_changed
);

    logic [NUM_SW-1:0] accept;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .sw_raw_i  (sw_raw[i]),
            .sw_db_o   (sw_db[i]),
            .sw_rise_o (sw_rise[i]),
            .sw_fall_o (sw_fall[i]),
            .accept_o  (accept[i])
        );
    end

    // One strobe per accepting edge, however many channels accept together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |accept;
        end
    end

endmodule
